led_pattern_sequencer: RTL

Playback controller for the 5-bit LED pattern memory in the SOC. It replaces the free-running PC with a sequenced player that supports start/stop, an address window, a per-step dwell time and three playback modes. It drives the pattern memory address and, one cycle later, captures the returned pattern into the LED register. It sits between the Clockworks-derived clk/resetn and the pattern memory/LEDS.

---
 rtl/led_pattern_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/led_pattern_sequencer.sv
// Sequenced playback of the LED pattern memory: start/stop, address window,
// per-step dwell time and one-shot / loop / ping-pong modes.
module led_pattern_sequencer #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 5,
  parameter int DWELL_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic [DWELL_W-1:0] dwell,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] leds,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, FETCH, LATCH, HOLD} state_t;

  localparam logic [ADDR_W-1:0]  AONE = ADDR_W'(1);
  localparam logic [DWELL_W-1:0] DONE_ = DWELL_W'(1);

  state_t             state, state_n;
  logic [1:0]         cfg_mode;
  logic [ADDR_W-1:0]  cfg_first, cfg_last;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [ADDR_W-1:0]  addr_n;
  logic [DATA_W-1:0]  leds_n;
  logic               dir_up, dir_up_n;
  logic               done_n;
  logic               start_ok;

  assign start_ok = start && !stop && (first_addr <= last_addr);

  always_comb begin
    state_n  = state;
    addr_n   = mem_addr;
    leds_n   = leds;
    dir_up_n = dir_up;
    cnt_n    = cnt;
    done_n   = 1'b0;
    if (stop && state != IDLE) begin
      state_n = IDLE;
    end else if (start_ok) begin
      addr_n   = first_addr;
      dir_up_n = 1'b1;
      state_n  = FETCH;
    end else begin
      unique case (state)
        IDLE:  state_n = IDLE;
        FETCH: state_n = LATCH;
        LATCH: begin
          leds_n  = mem_rdata;
          cnt_n   = cfg_dwell;
          state_n = HOLD;
        end
        HOLD: begin
          if (cnt != '0) begin
            cnt_n = cnt - DONE_;
          end else if (cfg_mode == 2'b00) begin
            if (mem_addr == cfg_last) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              addr_n  = mem_addr + AONE;
              state_n = FETCH;
            end
          end else if (cfg_mode == 2'b10) begin
            // Endpoints turn the direction and step away immediately so they
            // are never shown twice in a row; a one-entry window just repeats.
            state_n = FETCH;
            if (cfg_first == cfg_last) begin
              addr_n = mem_addr;
            end else if (dir_up) begin
              if (mem_addr == cfg_last) begin
                dir_up_n = 1'b0;
                addr_n   = mem_addr - AONE;
              end else begin
                addr_n = mem_addr + AONE;
              end
            end else begin
              if (mem_addr == cfg_first) begin
                dir_up_n = 1'b1;
                addr_n   = mem_addr + AONE;
              end else begin
                addr_n = mem_addr - AONE;
              end
            end
          end else begin
            state_n = FETCH;
            addr_n  = (mem_addr == cfg_last) ? cfg_first : mem_addr + AONE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      mem_addr  <= '0;
      leds      <= '0;
      dir_up    <= 1'b1;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_mode  <= '0;
      cfg_first <= '0;
      cfg_last  <= '0;
      cfg_dwell <= '0;
    end else begin
      state    <= state_n;
      mem_addr <= addr_n;
      leds     <= leds_n;
      dir_up   <= dir_up_n;
      cnt      <= cnt_n;
      busy     <= (state_n != IDLE);
      done     <= done_n;
      if (start_ok) begin
        cfg_mode  <= mode;
        cfg_first <= first_addr;
        cfg_last  <= last_addr;
        cfg_dwell <= dwell;
      end
    end
  end

endmodule
